// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - shared opcode and state definitions for logic_unit_pipe
//
// Purpose : opcode constants, opcode width and handshake state encodings
//           used by logic_unit_core and logic_unit_pipe.
// Ports   : none (package).
// Config  : LOGIC_UNIT_ZBB_EN (consumed by logic_unit_core) enables ANDN/ORN/XNOR.

package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_ANDN = 3'b011;
  localparam logic [OP_W-1:0] OP_ORN  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;

  // Occupancy of the output stage: main register only, or main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise logic operation with RV64 word mode
//
// Purpose : computes one bitwise logic operation on A and B.
// Ports   : i_op      opcode (see logic_unit_pkg)
//           i_word    word mode: 32-bit op, result sign-extended from bit 31 (XLEN=64 only)
//           i_a, i_b  operands
//           o_result  operation result (zero for illegal encodings)
//           o_illegal opcode is illegal or disabled in this build
// Config  : LOGIC_UNIT_ZBB_EN defined   -> ANDN/ORN/XNOR are legal
//           LOGIC_UNIT_ZBB_EN undefined -> ANDN/ORN/XNOR report illegal

module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [OP_W-1:0] i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  logic [XLEN-1:0] w_raw;

  always_comb begin
    w_raw     = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_AND:  w_raw = i_a & i_b;
      OP_OR:   w_raw = i_a | i_b;
      OP_XOR:  w_raw = i_a ^ i_b;
`ifdef LOGIC_UNIT_ZBB_EN
      OP_ANDN: w_raw = i_a & ~i_b;
      OP_ORN:  w_raw = i_a | ~i_b;
      OP_XNOR: w_raw = ~(i_a ^ i_b);
`endif
      default: begin
        w_raw     = '0;
        o_illegal = 1'b1;
      end
    endcase
  end

  // Bitwise ops never carry between bits, so a word-mode result is simply the
  // full-width result with its upper half replaced by copies of bit 31.
  generate
    if (XLEN == 64) begin : g_word
      assign o_result = i_word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;
    end else begin : g_no_word
      logic w_unused_word;
      assign w_unused_word = i_word;
      assign o_result      = w_raw;
    end
  endgenerate

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - pipelined logic unit with valid/ready handshake and skid buffer
//
// Purpose : single-cycle-latency, full-throughput bitwise logic execution unit.
// Ports   : clk, rst_n (async active-low), flush (sync, drops held entries)
//           in_valid/in_ready/in_op/in_word/in_a/in_b/in_tag : issue side
//           out_valid/out_ready/out_result/out_tag/out_illegal : writeback side
// Config  : LOGIC_UNIT_ZBB_EN enables ANDN/ORN/XNOR in logic_unit_core.

module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_in_ready;

  logic [XLEN-1:0]  r_main_result;
  logic [TAG_W-1:0] r_main_tag;
  logic             r_main_illegal;
  logic [XLEN-1:0]  r_skid_result;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_illegal;

  logic [XLEN-1:0]  w_core_result;
  logic             w_core_illegal;
  logic             w_accept;
  logic             w_deliver;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  logic_unit_core #(
    .XLEN(XLEN)
  ) u_core (
    .i_op      (in_op),
    .i_word    (in_word),
    .i_a       (in_a),
    .i_b       (in_b),
    .o_result  (w_core_result),
    .o_illegal (w_core_illegal)
  );

  // An operation presented during flush is discarded, never accepted.
  assign w_accept  = in_valid & r_in_ready & ~flush;
  assign w_deliver = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      // in_ready comes straight from a flop so it never depends on out_ready.
      r_in_ready <= (w_state_next != ST_TWO);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_ONE;
            w_load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_state_next = ST_TWO;
            w_load_skid  = 1'b1;
          end else if (w_deliver) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the skid entry can advance.
          if (w_deliver) begin
            w_state_next   = ST_ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_result  <= '0;
      r_main_tag     <= '0;
      r_main_illegal <= 1'b0;
      r_skid_result  <= '0;
      r_skid_tag     <= '0;
      r_skid_illegal <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_result  <= w_core_result;
        r_main_tag     <= in_tag;
        r_main_illegal <= w_core_illegal;
      end else if (w_skid_to_main) begin
        r_main_result  <= r_skid_result;
        r_main_tag     <= r_skid_tag;
        r_main_illegal <= r_skid_illegal;
      end
      if (w_load_skid) begin
        r_skid_result  <= w_core_result;
        r_skid_tag     <= in_tag;
        r_skid_illegal <= w_core_illegal;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_result  = r_main_result;
  assign out_tag     = r_main_tag;
  assign out_illegal = r_main_illegal;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe (XLEN=64, TAG_W=5)

module tb_logic_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_word;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        out_illegal;

  logic_unit_pipe #(.XLEN(64), .TAG_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_word     (in_word),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference semantics written straight from the opcode table.
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic        ill;
    logic        zbb;
`ifdef LOGIC_UNIT_ZBB_EN
    zbb = 1'b1;
`else
    zbb = 1'b0;
`endif
    ill = 1'b0;
    r   = 64'd0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: if (zbb) r = a & ~b; else ill = 1'b1;
      3'd4: if (zbb) r = a | ~b; else ill = 1'b1;
      3'd5: if (zbb) r = ~(a ^ b); else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    if (ill) r = 64'd0;
    if (w) r = 64'($signed(r[31:0]));
    return {ill, r};
  endfunction

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t       mq[$];     // results in flight, oldest first; capacity 2
  logic [4:0] got_tags[$];
  int         n_del = 0;

  // Model update on the clock edge using pre-edge handshake values.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (out_valid && out_ready) begin
        got_tags.push_back(out_tag);
        n_del++;
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if (flush) begin
        mq.delete();
      end else if (in_valid && in_ready) begin
        logic [64:0] r;
        exp_t e;
        r = ref_op(in_op, in_word, in_a, in_b);
        e.res = r[63:0];
        e.ill = r[64];
        e.tag = in_tag;
        mq.push_back(e);
      end
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      if (out_valid && mq.size() != 0) begin
        chk("out_result", out_result, mq[0].res);
        chk("out_tag", 64'(out_tag), 64'(mq[0].tag));
        chk("out_illegal", 64'(out_illegal), 64'(mq[0].ill));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_word  = w;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // One op with out_ready high; result must be visible one cycle later.
  task automatic issue(input string nm, input logic [2:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                       input logic [63:0] exp_res, input logic exp_ill);
    @(negedge clk);
    out_ready = 1'b1;
    drive(op, w, a, b, tag);
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_result"}, out_result, exp_res);
    chk({nm, "_illegal"}, 64'(out_illegal), 64'(exp_ill));
    chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  task automatic fill_two(input logic [4:0] t1, input logic [4:0] t2);
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'd1, 1'b0, 64'(t1), 64'd0, t1);
    @(negedge clk);
    drive(3'd1, 1'b0, 64'(t2), 64'd0, t2);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] held_res;
    logic [4:0]  held_tag;
    int          base;
    int          guard;
    logic        zbb;
`ifdef LOGIC_UNIT_ZBB_EN
    zbb = 1'b1;
`else
    zbb = 1'b0;
`endif

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 3'd0; in_word = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Pin the model with hand-computed values.
    chk("ref_and", ref_op(3'd0, 1'b0, 64'hF0, 64'h3C), {1'b0, 64'h30});
    chk("ref_xor_word", ref_op(3'd2, 1'b1, 64'h0, 64'h8000_0001), {1'b0, 64'hFFFF_FFFF_8000_0001});
    chk("ref_illegal", ref_op(3'd7, 1'b0, '1, '1), {1'b1, 64'h0});

    // 1. Sweep: A over 0..255, B over 16 spread values, every opcode, full throughput.
    base = n_del;
    for (int op = 0; op < 6; op++) begin
      for (int a = 0; a < 256; a++) begin
        for (int b = 0; b < 16; b++) begin
          @(negedge clk);
          drive(3'(op), 1'b0, 64'(a), 64'(b * 17), 5'(a + b));
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sweep_count", 64'(n_del - base), 64'd24576);

    // 2. Word mode sign extension.
    issue("word_neg", 3'd0, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    issue("word_pos", 3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, '1, 5'd2, 64'h0000_0000_7FFF_FFFF, 1'b0);
    issue("full_and", 3'd0, 1'b0, 64'hFFFF_0000_8000_0000, '1, 5'd3, 64'hFFFF_0000_8000_0000, 1'b0);

    // 3. Backpressure with tags 1,2,3.
    @(negedge clk);
    got_tags.delete();
    out_ready = 1'b0;
    drive(3'd2, 1'b0, 64'h11, 64'h0, 5'd1);
    @(negedge clk);
    drive(3'd2, 1'b0, 64'h22, 64'h0, 5'd2);
    @(negedge clk);
    drive(3'd2, 1'b0, 64'h33, 64'h0, 5'd3);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_tag", 64'(out_tag), 64'd1);
    held_res = out_result;
    held_tag = out_tag;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stable_result", out_result, held_res);
      chk("bp_stable_tag", 64'(out_tag), 64'(held_tag));
      chk("bp_stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_in_ready_return", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_count", 64'(got_tags.size()), 64'd3);
    if (got_tags.size() == 3) begin
      chk("bp_order0", 64'(got_tags[0]), 64'd1);
      chk("bp_order1", 64'(got_tags[1]), 64'd2);
      chk("bp_order2", 64'(got_tags[2]), 64'd3);
    end

    // 4. Illegal and build-dependent encodings.
    issue("ill_110", 3'd6, 1'b0, '1, '1, 5'd4, 64'd0, 1'b1);
    issue("op_011", 3'd3, 1'b0, '1, '1, 5'd5, 64'd0, !zbb);
    issue("op_100", 3'd4, 1'b0, 64'h0, 64'h0, 5'd6, zbb ? '1 : 64'd0, !zbb);

    // 5. Flush from TWO with a concurrent in_valid, then from ONE.
    fill_two(5'd8, 5'd9);
    got_tags.delete();
    @(negedge clk);
    flush = 1'b1;
    drive(3'd0, 1'b0, '1, '1, 5'd7);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush2_out_valid", 64'(out_valid), 64'd0);
    chk("flush2_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(3'd0, 1'b0, '1, '1, 5'd10);
    @(negedge clk);
    flush = 1'b1;
    drive(3'd0, 1'b0, '1, '1, 5'd7);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush1_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_no_delivery", 64'(got_tags.size()), 64'd0);

    // 6. Asynchronous reset between edges while in TWO.
    fill_two(5'd11, 5'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    chk("arst_out_illegal", 64'(out_illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst", 3'd0, 1'b0, 64'hF0, 64'h3C, 5'd13, 64'h30, 1'b0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
